// File: rtl/p2s_pkg.sv
// Shared types and frame-geometry helpers for the multichannel parallel-to-serial transmitter.
// Optional feature: P2S_PARITY_EN appends one even-parity bit per lane.
package p2s_pkg;

  typedef enum logic [0:0] {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

`ifdef P2S_PARITY_EN
  localparam bit P2sParityEn = 1'b1;
`else
  localparam bit P2sParityEn = 1'b0;
`endif

  function automatic int unsigned p2s_frame_len(input int unsigned data_w, input bit parity_en);
    return data_w + (parity_en ? 32'd1 : 32'd0);
  endfunction

  // Never narrower than one bit, even for a degenerate one-bit frame.
  function automatic int unsigned p2s_cnt_w(input int unsigned data_w, input bit parity_en);
    int unsigned len;
    len = p2s_frame_len(data_w, parity_en);
    return (len > 32'd1) ? $clog2(len) : 32'd1;
  endfunction

endpackage

// File: rtl/p2s_lane.sv
// One serial lane: holding buffer, shift register and output bit select.
// With P2S_PARITY_EN the lane also carries the even-parity bit of the loaded word.
module p2s_lane
  import p2s_pkg::*;
#(
  parameter int unsigned DATA_W    = 40,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              cap_i,
  input  logic              ld_direct_i,
  input  logic              ld_buf_i,
  input  logic              shift_i,
`ifdef P2S_PARITY_EN
  input  logic              par_sel_i,
`endif
  output logic              bit_o
);

  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;

  always_comb begin
    buf_d  = buf_q;
    sreg_d = sreg_q;
    if (cap_i) begin
      buf_d = data_i;
    end
    if (ld_direct_i) begin
      sreg_d = data_i;
    end else if (ld_buf_i) begin
      sreg_d = buf_q;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
      end else begin
        sreg_d = {1'b0, sreg_q[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q  <= '0;
      sreg_q <= '0;
    end else begin
      buf_q  <= buf_d;
      sreg_q <= sreg_d;
    end
  end

`ifdef P2S_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (ld_direct_i) begin
      par_d = ^data_i;
    end else if (ld_buf_i) begin
      par_d = ^buf_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  always_comb begin
    if (par_sel_i) begin
      bit_o = par_q;
    end else begin
      bit_o = MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0];
    end
  end
`else
  assign bit_o = MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0];
`endif

endmodule

// File: rtl/p2s_multichan.sv
// Multichannel parallel-to-serial transmitter with a one-word holding buffer for gapless frames.
// Optional feature: P2S_PARITY_EN extends every frame by one even-parity bit.
module p2s_multichan
  import p2s_pkg::*;
#(
  parameter int unsigned DATA_W    = 40,
  parameter int unsigned NUM_CH    = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     SCLK,
  input  logic                     CLR,
  input  logic                     LOAD,
  input  logic [NUM_CH*DATA_W-1:0] PDATAIN,
  output logic [NUM_CH-1:0]        DATAOUT,
  output logic                     OutReady,
  output logic                     FRAME_START,
  output logic                     LOAD_RDY,
  output logic                     OVERRUN
);

  localparam int unsigned FrameLen = p2s_frame_len(DATA_W, P2sParityEn);
  localparam int unsigned CntW     = p2s_cnt_w(DATA_W, P2sParityEn);
  localparam logic [CntW-1:0] CntLast = CntW'(FrameLen - 1);

  p2s_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            ovr_q, ovr_d;

  logic cap, ld_direct, ld_buf, shift;
  logic [NUM_CH-1:0] lane_bits;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    ovr_d     = ovr_q;
    cap       = 1'b0;
    ld_direct = 1'b0;
    ld_buf    = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      P2S_IDLE: begin
        // The buffer is always empty here, so a load goes straight to the shift register.
        if (LOAD) begin
          ld_direct = 1'b1;
          cnt_d     = '0;
          state_d   = P2S_SHIFT;
        end
      end
      P2S_SHIFT: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (full_q) begin
            // Buffered word moves on; a concurrent LOAD refills the freed slot.
            ld_buf = 1'b1;
            cap    = LOAD;
            full_d = LOAD;
          end else if (LOAD) begin
            ld_direct = 1'b1;
          end else begin
            state_d = P2S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          shift = 1'b1;
          if (LOAD) begin
            if (!full_q) begin
              cap    = 1'b1;
              full_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = P2S_IDLE;
    endcase
  end

  always_ff @(posedge SCLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= P2S_IDLE;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef P2S_PARITY_EN
  logic par_sel;
  assign par_sel = (cnt_q == CntW'(DATA_W));
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    p2s_lane #(
      .DATA_W   (DATA_W),
      .MSB_FIRST(MSB_FIRST)
    ) u_lane (
      .clk_i      (SCLK),
      .rst_ni     (CLR),
      .data_i     (PDATAIN[c*DATA_W +: DATA_W]),
      .cap_i      (cap),
      .ld_direct_i(ld_direct),
      .ld_buf_i   (ld_buf),
      .shift_i    (shift),
`ifdef P2S_PARITY_EN
      .par_sel_i  (par_sel),
`endif
      .bit_o      (lane_bits[c])
    );
  end

  assign OutReady    = (state_q == P2S_SHIFT);
  assign FRAME_START = OutReady && (cnt_q == '0);
  assign DATAOUT     = OutReady ? lane_bits : '0;
  assign LOAD_RDY    = !full_q;
  assign OVERRUN     = ovr_q;

endmodule
